proj_fm_reader: RTL and testbench
=================================

# proj_fm_reader

Read-side sequencer for the feature-map buffer. When the write-side index counter signals that the buffer is full, this block walks the buffer from address 0 to BUF_SIZE-1. It issues synchronous reads with 1-cycle latency and streams the words downstream over a valid/ready interface, with a last flag and a completion pulse. Back-pressure is absorbed by a 2-entry output FIFO with credit-gated read issue, so no word is lost or duplicated.

## Interface
- INDICE_LEN, default proj_pkg::INDICE_LEN: buffer address width.
- BUF_SIZE, default proj_pkg::FM_BUFFER_SIZE: number of words read per pass; legal range 1..2^INDICE_LEN.
- DATA_W, default 8: buffer word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fill_done  in  1  1-cycle pulse from the write-side counter: buffer is full.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  INDICE_LEN  buffer read address. Valid when rd_en is high.
- rd_data  in  DATA_W  buffer read data. Valid exactly 1 cycle after rd_en.
- m_valid  out  1  output word valid.
- m_data  out  DATA_W  output word.
- m_last  out  1  high with the word read from address BUF_SIZE-1.
- m_ready  in  1  downstream accept.
- busy  out  1  high from the cycle after fill_done is accepted until done.
- done  out  1  1-cycle pulse, the cycle after the last-word handshake.
- buf_free  out  1  level; high in IDLE, meaning the writer may refill.
- err_overrun  out  1  sticky; set when fill_done arrives while busy. Cleared only by reset.

## Operation
- FSM states:
  - IDLE: fill_done -> READ; rd_ptr <= 0.
  - READ: issue reads while credit allows. After issuing address BUF_SIZE-1 -> DRAIN.
  - DRAIN: no reads. On the m_last handshake -> IDLE, and done is registered high for 1 cycle.
- Credit rule:
  - used = fifo_occupancy + inflight, where inflight means rd_en was asserted in the previous cycle.
  - pop = m_valid & m_ready.
  - rd_en = (state==READ) & (used - pop <= 1).
  - rd_ptr increments by 1 on each rd_en.
- Output FIFO:
  - rd_data is pushed into the 2-entry FIFO in the cycle after rd_en.
  - m_valid = FIFO not empty; m_data/m_last come from the FIFO head.
  - A push and a pop in the same cycle are legal.
  - The FIFO never overflows; overflow is an assertion failure.
- m_last tag: carried alongside each word and set when the issued address equals BUF_SIZE-1.
- Address arithmetic: rd_ptr is INDICE_LEN bits and never wraps within a pass. It restarts at 0 on every accepted fill_done.
- fill_done while busy: ignored, and err_overrun is set. The current pass is unaffected.
- fill_done in the same cycle as done: busy is already low in that cycle, so it is accepted and starts a new pass.
- m_valid rules:
  - Once m_valid is high, m_data and m_last stay stable until the handshake.
  - m_valid never drops without a handshake.
- BUF_SIZE==1: one read is issued, READ -> DRAIN immediately, and the single beat carries m_last=1.

## Timing
- Reset values: rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, buf_free=1, err_overrun=0. State is IDLE and the FIFO is empty.
- Reset mid-pass aborts immediately: the FIFO is flushed, no done pulse is produced, and the next pass starts from address 0.
- Latency and throughput (cycle numbers relative to fill_done sampled high in cycle 0):
  - Cycle 1: busy=1, buf_free=0, rd_en=1, rd_addr=0.
  - Cycle 2: rd_data for address 0 is valid at the buffer and is pushed into the FIFO.
  - Cycle 3: first m_valid.
  - With m_ready held high: one beat per cycle over cycles 3..BUF_SIZE+2; m_last in cycle BUF_SIZE+2.
  - Cycle BUF_SIZE+3: done=1, busy=0, buf_free=1.
- Back-pressure: while m_ready=0, at most 2 words are buffered and rd_en stays low once used=2. Issue resumes in the same cycle that a pop occurs.
- done is registered and never coincides with m_valid of the same pass.

## Test plan
- BUF_SIZE=8, buffer preloaded with data=addr+0x10, m_ready=1, fill_done pulse in cycle 0:
  - rd_en in cycles 1..8.
  - m_data 0x10..0x17 in cycles 3..10, with m_last only in cycle 10.
  - done in cycle 11; busy high over cycles 1..10.
- Same setup, m_ready=0 for cycles 0..9, then 1:
  - exactly 2 reads are issued (addresses 0 and 1).
  - m_data holds 0x10 until cycle 10.
  - all 8 words are delivered in order, with no duplicates and no gaps.
- Random m_ready (50%) over 100 passes: every pass delivers 0x10..0x17 in order, exactly one m_last and one done per pass, and the FIFO never overflows.
- Second fill_done in cycle 4 of a pass: the stream is unchanged and err_overrun=1 stays set until reset. Another fill_done in the done cycle starts a fresh pass at address 0.
- rst_n low in cycle 5 of a pass: all outputs return to their reset values asynchronously, with no done pulse. The next fill_done restarts at rd_addr=0.
- BUF_SIZE=1: a single beat with m_last=1 in cycle 3, and done in cycle 4.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared project parameters for the feature-map datapath.
package proj_pkg;
  localparam int INDICE_LEN     = 8;
  localparam int FM_BUFFER_SIZE = 8;
endpackage

// File: rtl/proj_fm_reader.sv
// Read-side sequencer for the feature-map buffer: walks addresses 0..BUF_SIZE-1
// after each fill and streams the words out through a 2-entry credit-gated FIFO.
module proj_fm_reader #(
  parameter int INDICE_LEN = proj_pkg::INDICE_LEN,
  parameter int BUF_SIZE   = proj_pkg::FM_BUFFER_SIZE,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fill_done,
  output logic                  rd_en,
  output logic [INDICE_LEN-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  m_valid,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_free,
  output logic                  err_overrun
);

  // Handshake: a beat transfers on a rising edge where m_valid && m_ready; once
  // m_valid rises, m_data/m_last hold until that transfer and m_valid never drops early.

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_e;

  localparam logic [INDICE_LEN-1:0] LAST_ADDR = INDICE_LEN'(BUF_SIZE - 1);

  state_e                     state_q, state_d;
  logic [INDICE_LEN-1:0]      rd_ptr_q, rd_ptr_d;
  logic                       inflight_q, inflight_d;
  logic                       inflight_last_q, inflight_last_d;
  logic [1:0][DATA_W-1:0]     fifo_data_q, fifo_data_d;
  logic [1:0]                 fifo_last_q, fifo_last_d;
  logic                       wr_idx_q, wr_idx_d;
  logic                       rd_idx_q, rd_idx_d;
  logic [1:0]                 count_q, count_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic       push;
  logic       pop;
  logic       head_last;
  logic [2:0] used;
  logic       rd_en_c;

  always_comb begin
    push      = inflight_q;
    pop       = (count_q != 2'd0) && m_ready;
    head_last = fifo_last_q[rd_idx_q];
    used      = 3'(count_q) + 3'(inflight_q);
    // Issue only if the word would still have a FIFO slot after this cycle's pop.
    rd_en_c   = (state_q == ST_READ) && (used <= 3'd1 + 3'(pop));

    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_done) begin
          state_d  = ST_READ;
          rd_ptr_d = '0;
        end
      end
      ST_READ: begin
        if (rd_en_c) begin
          rd_ptr_d = rd_ptr_q + INDICE_LEN'(1);
          if (rd_ptr_q == LAST_ADDR) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d          = (state_q == ST_DRAIN) && pop && head_last;
    err_d           = err_q | (fill_done && (state_q != ST_IDLE));
    inflight_d      = rd_en_c;
    inflight_last_d = rd_en_c && (rd_ptr_q == LAST_ADDR);

    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_idx_q] = rd_data;
      fifo_last_d[wr_idx_q] = inflight_last_q;
    end
    wr_idx_d = wr_idx_q ^ push;
    rd_idx_d = rd_idx_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '0;
      fifo_last_q     <= '0;
      wr_idx_q        <= 1'b0;
      rd_idx_q        <= 1'b0;
      count_q         <= 2'd0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_ptr_q        <= rd_ptr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      count_q         <= count_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign rd_en       = rd_en_c;
  assign rd_addr     = rd_ptr_q;
  assign m_valid     = (count_q != 2'd0);
  assign m_data      = fifo_data_q[rd_idx_q];
  // The head slot keeps its last tag after draining, so qualify it with valid.
  assign m_last      = m_valid && head_last;
  assign busy        = (state_q != ST_IDLE);
  assign buf_free    = (state_q == ST_IDLE);
  assign done        = done_q;
  assign err_overrun = err_q;

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_proj_fm_reader.sv
// Directed and randomized checks of proj_fm_reader against a word-stream model
// of a buffer preloaded with addr+0x10.
module tb_proj_fm_reader;

  localparam int AW = 8;
  localparam int DW = 8;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: BUF_SIZE=8
  logic          fill_done, rd_en, m_valid, m_last, m_ready, busy, done, buf_free, err_overrun;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;

  // DUT1: BUF_SIZE=1
  logic          fill_done1, rd_en1, m_valid1, m_last1, m_ready1, busy1, done1, buf_free1, err_overrun1;
  logic [AW-1:0] rd_addr1;
  logic [DW-1:0] rd_data1, m_data1;

  proj_fm_reader #(.INDICE_LEN(AW), .BUF_SIZE(8), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .fill_done(fill_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .done(done), .buf_free(buf_free),
    .err_overrun(err_overrun)
  );

  proj_fm_reader #(.INDICE_LEN(AW), .BUF_SIZE(1), .DATA_W(DW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fill_done(fill_done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .m_valid(m_valid1), .m_data(m_data1), .m_last(m_last1),
    .m_ready(m_ready1), .busy(busy1), .done(done1), .buf_free(buf_free1),
    .err_overrun(err_overrun1)
  );

  // buffer model: synchronous read, 1-cycle latency
  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
  always @(posedge clk) if (rd_en)  rd_data  <= mem[rd_addr];
  always @(posedge clk) if (rd_en1) rd_data1 <= mem[rd_addr1];

  int n_assert = 0;
  int n_fail   = 0;
  int last_cnt = 0;
  int done_cnt = 0;

  logic [DW:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference stream for one pass of an n-word buffer
  task automatic push_pass(input int n);
    for (int a = 0; a < n; a++) exp_q.push_back({a == n - 1, 8'(a + 16)});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"},   rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"},  m_data, 0);
    check({tag, "_m_last"},  m_last, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_buf_free"}, buf_free, 1);
    check({tag, "_err"},     err_overrun, 0);
  endtask

  // scoreboard: every accepted beat must match the head of exp_q; stalled beats must hold
  logic [DW:0] prev_word;
  logic        prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_word", {m_last, m_data}, prev_word);
      end
      if (m_valid && m_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("beat_word", {m_last, m_data}, exp_q.pop_front());
        if (m_last) last_cnt++;
      end
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nreads;
    logic got_done;

    rst_n = 1'b0; fill_done = 1'b0; m_ready = 1'b0; fill_done1 = 1'b0; m_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    next_cycle();

    // full-rate pass with exact cycle timing
    push_pass(8);
    m_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      fill_done = (c == 0);
      @(negedge clk);
      check("p1_rd_en", rd_en, (c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) check("p1_rd_addr", rd_addr, c - 1);
      check("p1_m_valid", m_valid, (c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) check("p1_m_data", m_data, 16 + c - 3);
      check("p1_m_last", m_last, (c == 10));
      check("p1_done", done, (c == 11));
      check("p1_busy", busy, (c >= 1 && c <= 10));
      check("p1_buf_free", buf_free, !(c >= 1 && c <= 10));
      next_cycle();
    end
    fill_done = 1'b0;
    check("p1_stream_empty", exp_q.size(), 0);

    // back-pressure: m_ready low through cycle 9
    push_pass(8);
    nreads = 0;
    got_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      fill_done = (c == 0);
      m_ready   = (c >= 10);
      @(negedge clk);
      if (rd_en) begin
        check("p2_rd_addr", rd_addr, nreads);
        nreads++;
      end
      if (c == 9) check("p2_reads_stalled", nreads, 2);
      if (c >= 3 && c <= 10) begin
        check("p2_m_valid", m_valid, 1);
        check("p2_m_data", m_data, 8'h10);
      end
      if (done) got_done = 1'b1;
      next_cycle();
      if (got_done) break;
    end
    fill_done = 1'b0;
    check("p2_done_seen", got_done, 1);
    check("p2_reads_total", nreads, 8);
    check("p2_stream_empty", exp_q.size(), 0);

    // random back-pressure passes
    for (int p = 0; p < 100; p++) begin
      push_pass(8);
      last_cnt = 0;
      done_cnt = 0;
      got_done = 1'b0;
      for (int c = 0; c < 300; c++) begin
        fill_done = (c == 0);
        m_ready   = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (done) got_done = 1'b1;
        next_cycle();
        if (got_done) break;
      end
      fill_done = 1'b0;
      check("p3_done_seen", got_done, 1);
      check("p3_stream_empty", exp_q.size(), 0);
      check("p3_last_count", last_cnt, 1);
      check("p3_done_count", done_cnt, 1);
    end

    // overrun mid-pass, then restart in the done cycle
    push_pass(8);
    push_pass(8);
    m_ready  = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      fill_done = (c == 0 || c == 4 || c == 11);
      @(negedge clk);
      check("p4_err", err_overrun, (c >= 5));
      check("p4_rd_en", rd_en, ((c >= 1 && c <= 8) || (c >= 12 && c <= 19)));
      if (c >= 1 && c <= 8)   check("p4_rd_addr_a", rd_addr, c - 1);
      if (c >= 12 && c <= 19) check("p4_rd_addr_b", rd_addr, c - 12);
      check("p4_done", done, (c == 11 || c == 22));
      if (c == 11) check("p4_busy_done_cycle", busy, 0);
      next_cycle();
    end
    fill_done = 1'b0;
    check("p4_stream_empty", exp_q.size(), 0);
    check("p4_done_count", done_cnt, 2);

    // asynchronous reset in cycle 5 of a pass
    push_pass(8);
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      fill_done = (c == 0);
      @(negedge clk);
      next_cycle();
    end
    fill_done = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("p5_async");
    exp_q.delete();
    @(negedge clk);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("p5_no_done", done, 0);
      check("p5_idle", busy, 0);
      next_cycle();
    end
    push_pass(8);
    got_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      fill_done = (c == 0);
      @(negedge clk);
      if (c == 1) begin
        check("p5_restart_rd_en", rd_en, 1);
        check("p5_restart_addr", rd_addr, 0);
      end
      if (done) got_done = 1'b1;
      next_cycle();
      if (got_done) break;
    end
    fill_done = 1'b0;
    check("p5_done_seen", got_done, 1);
    check("p5_done_count", done_cnt, 1);
    check("p5_stream_empty", exp_q.size(), 0);

    // BUF_SIZE=1 instance
    for (int c = 0; c < 7; c++) begin
      fill_done1 = (c == 0);
      @(negedge clk);
      check("p6_rd_en", rd_en1, (c == 1));
      if (c == 1) check("p6_rd_addr", rd_addr1, 0);
      check("p6_m_valid", m_valid1, (c == 3));
      check("p6_m_last", m_last1, (c == 3));
      if (c == 3) check("p6_m_data", m_data1, 8'h10);
      check("p6_done", done1, (c == 4));
      check("p6_busy", busy1, (c >= 1 && c <= 3));
      next_cycle();
    end
    fill_done1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
